// File: rtl/gost89_round_if.sv
// gost89_round_if -- data bus between a GOST 28147-89 round controller and
// the gost89_round datapath.
//
// Signals:
//   sbox       512  eight 16x4-bit substitution tables (table i in [64i+63:64i])
//   round_key  32   subkey for the current round
//   n1         32   active half (fed through the round function)
//   n2         32   passive half
//   out1       32   new n1 = n2 ^ rotl11(S(n1 + round_key))
//   out2       32   new n2 = n1
//
// Modports:
//   master  controller side: drives the operands and consumes the results
//   slave   round datapath side

interface gost89_round_if;
  logic [511:0] sbox;
  logic [31:0]  round_key;
  logic [31:0]  n1;
  logic [31:0]  n2;
  logic [31:0]  out1;
  logic [31:0]  out2;

  modport master (
    output sbox,
    output round_key,
    output n1,
    output n2,
    input  out1,
    input  out2
  );

  modport slave (
    input  sbox,
    input  round_key,
    input  n1,
    input  n2,
    output out1,
    output out2
  );
endinterface

// File: rtl/gost89_round.sv
// gost89_round -- one Feistel round of GOST 28147-89.
//
// The round computes
//   sum  = (n1 + round_key) mod 2^32
//   sub  = S(sum), nibble i looked up in table i
//   out1 = rotl11(sub) ^ n2
//   out2 = n1
// An external controller owns round counting, key scheduling and the
// final half swap, and feeds out1/out2 back into n1/n2.
//
// Ports:
//   clk    in   clock (only used when GOST89_ROUND_REG_EN is defined)
//   reset  in   synchronous active-high reset (only used when
//               GOST89_ROUND_REG_EN is defined; clears out1/out2)
//   bus    slave modport of gost89_round_if (sbox, round_key, n1, n2 in;
//          out1, out2 out)
//
// Configuration macro:
//   GOST89_ROUND_REG_EN  undefined: purely combinational, zero latency.
//                        defined:   out1/out2 registered, one cycle latency.

module gost89_round (
  input  logic                 clk,
  input  logic                 reset,
  gost89_round_if.slave        bus
);

  logic [31:0] sum;
  logic [31:0] sub;
  logic [31:0] f;
  logic [31:0] out1_d;
  logic [31:0] out2_d;

  // Modular add; the carry out of bit 31 is intentionally dropped.
  assign sum = bus.n1 + bus.round_key;

  // Nibble i of sum selects entry v of table i, which lives at
  // sbox[64i + 4v +: 4]. The bit offset is built by concatenation
  // {i, v, 2'b00} so it is exactly 9 bits wide with no multiply.
  for (genvar g = 0; g < 8; g++) begin : gen_sbox
    localparam logic [2:0] TBL = 3'(g);
    assign sub[4*g +: 4] = bus.sbox[{TBL, sum[4*g +: 4], 2'b00} +: 4];
  end

  // Rotate left by 11.
  assign f = {sub[20:0], sub[31:21]};

  assign out1_d = f ^ bus.n2;
  assign out2_d = bus.n1;

`ifdef GOST89_ROUND_REG_EN
  logic [31:0] out1_q;
  logic [31:0] out2_q;

  // Reset wins over the computed value, so a reset pulse mid-stream
  // discards that round's result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out1_q <= 32'h0;
      out2_q <= 32'h0;
    end else begin
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign bus.out1 = out1_q;
  assign bus.out2 = out2_q;
`else
  // Combinational build: clk and reset are kept on the port list so the
  // two builds are pin-compatible, but they have no function here.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign bus.out1 = out1_d;
  assign bus.out2 = out2_d;
`endif

endmodule

// File: tb/tb_gost89_round.sv
module tb_gost89_round;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  gost89_round_if bus ();

  gost89_round u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] sbox_identity();
    logic [511:0] s;
    s = '0;
    for (int t = 0; t < 8; t++)
      for (int v = 0; v < 16; v++)
        s[64*t + 4*v +: 4] = 4'(v);
    return s;
  endfunction

  function automatic logic [511:0] sbox_complement();
    logic [511:0] s;
    s = '0;
    for (int t = 0; t < 8; t++)
      for (int v = 0; v < 16; v++)
        s[64*t + 4*v +: 4] = ~4'(v);
    return s;
  endfunction

  // Reference model written from the formulas, using shifts for the rotate.
  function automatic logic [31:0] model_out1(input logic [511:0] s, input logic [31:0] k,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sm;
    logic [31:0] sb;
    logic [3:0]  v;
    sm = a + k;
    sb = '0;
    for (int t = 0; t < 8; t++) begin
      v = sm[4*t +: 4];
      sb[4*t +: 4] = s[64*t + 4*int'(v) +: 4];
    end
    return (sb << 11) | (sb >> 21);
  endfunction

  // Apply operands and wait until the result is visible at the outputs.
  task automatic apply(input logic [511:0] s, input logic [31:0] k,
                       input logic [31:0] a, input logic [31:0] b);
    bus.sbox      = s;
    bus.round_key = k;
    bus.n1        = a;
    bus.n2        = b;
`ifdef GOST89_ROUND_REG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  logic [511:0] s_id;
  logic [511:0] s_cp;
  logic [511:0] s_t3;
  logic [511:0] s_rnd;
  logic [31:0]  rk, ra, rb, e1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bus.sbox      = '0;
    bus.round_key = '0;
    bus.n1        = '0;
    bus.n2        = '0;

    s_id = sbox_identity();
    s_cp = sbox_complement();
    s_t3 = '0;
    s_t3[64*3 +: 64] = {16{4'hA}};

    @(negedge clk);

`ifdef GOST89_ROUND_REG_EN
    // T6: reset clears both outputs even with live operands present.
    bus.sbox = s_id; bus.round_key = 32'h1; bus.n1 = 32'h0; bus.n2 = 32'h0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_out1", bus.out1, 32'h0);
    check("t6_rst_out2", bus.out2, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_resume_out1", bus.out1, 32'h00000800);
    check("t6_resume_out2", bus.out2, 32'h0);
    // Mid-stream reset discards that cycle's result.
    bus.n1 = 32'h12345678; bus.round_key = 32'h11111111;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_mid_rst_out1", bus.out1, 32'h0);
    check("t6_mid_rst_out2", bus.out2, 32'h0);
    reset = 1'b0;
`endif

    apply(s_id, 32'h1, 32'h0, 32'h0);
    check("t1_out1", bus.out1, 32'h00000800);
    check("t1_out2", bus.out2, 32'h00000000);

    apply(s_id, 32'h1, 32'hFFFFFFFF, 32'hDEADBEEF);
    check("t2_wrap_out1", bus.out1, 32'hDEADBEEF);
    check("t2_wrap_out2", bus.out2, 32'hFFFFFFFF);

    apply(s_id, 32'h0, 32'h80000000, 32'h0);
    check("t3_rot_out1", bus.out1, 32'h00000400);
    check("t3_rot_out2", bus.out2, 32'h80000000);

    apply(s_cp, 32'h0, 32'h0, 32'h0F0F0F0F);
    check("t4_cpl_out1", bus.out1, 32'hF0F0F0F0);
    check("t4_cpl_out2", bus.out2, 32'h0);

    apply(s_t3, 32'h0, 32'h0, 32'h0);
    check("t5_tbl3_out1", bus.out1, 32'h05000000);

    apply(s_id, 32'h11111111, 32'h12345678, 32'h0);
    check("mix_out1", bus.out1, 32'h2B3C491A);
    check("mix_out2", bus.out2, 32'h12345678);

`ifndef GOST89_ROUND_REG_EN
    // Combinational build: reset must not disturb the outputs.
    reset = 1'b1;
    apply(s_id, 32'h1, 32'h0, 32'h0);
    check("noreg_reset_out1", bus.out1, 32'h00000800);
    @(posedge clk); #1;
    check("noreg_reset_edge_out1", bus.out1, 32'h00000800);
    reset = 1'b0;
`endif

    s_rnd = '0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0)
        for (int w = 0; w < 16; w++) s_rnd[32*w +: 32] = $urandom;
      rk = $urandom;
      ra = $urandom;
      rb = $urandom;
      e1 = model_out1(s_rnd, rk, ra, rb) ^ rb;
      apply(s_rnd, rk, ra, rb);
      check("rnd_out1", bus.out1, e1);
      check("rnd_out2", bus.out2, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
